// File: rtl/branch_redirect_unit.sv
// Frontend recovery for the oldest mispredicted branch:
// latches the record, redirects fetch and holds the flush window.
module branch_redirect_unit #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [75:0] IN_branch,
  input  logic [6:0]  IN_ROB_curSqN,
  input  logic [6:0]  IN_RN_nextSqN,
  output logic        OUT_redirValid,
  output logic [31:0] OUT_redirPC,
  output logic [4:0]  OUT_redirFetchID,
  output logic [15:0] OUT_redirHistory,
  output logic        OUT_mispredFlush,
  output logic [6:0]  OUT_flushSqN,
  output logic [6:0]  OUT_flushLoadSqN,
  output logic [6:0]  OUT_flushStoreSqN,
  output logic        OUT_stallRename
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  sqn;
    logic [6:0]  lsqn;
    logic [6:0]  ssqn;
    logic        flush;
    logic [4:0]  fid;
    logic [15:0] hist;
    logic        vld;
  } br_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } state_t;

  br_t         in_br;
  state_t      state_q;
  state_t      state_n;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_n;
  logic [31:0] rec_pc;
  logic [4:0]  rec_fid;
  logic [15:0] rec_hist;
  logic [6:0]  sqn_diff;
  logic        older;
  logic        accept;
  logic        redir_n;
  logic [31:0] src_pc;
  logic [4:0]  src_fid;
  logic [15:0] src_hist;

  assign in_br = br_t'(IN_branch);

  // Sign of the modulo-128 difference orders wrapping sqNs.
  assign sqn_diff = in_br.sqn - OUT_flushSqN;
  assign older    = sqn_diff[6];
  assign accept   = in_br.vld &&
                    ((state_q == IDLE) || older);

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    redir_n  = 1'b0;
    src_pc   = rec_pc;
    src_fid  = rec_fid;
    src_hist = rec_hist;
    if (accept) begin
      src_pc   = in_br.pc;
      src_fid  = in_br.fid;
      src_hist = in_br.hist;
      if (in_br.flush) begin
        state_n = DRAIN;
      end else begin
        state_n = FLUSH;
        cnt_n   = CNT_LOAD;
        redir_n = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_n = IDLE;
        end
        DRAIN: begin
          if (IN_ROB_curSqN == IN_RN_nextSqN) begin
            state_n = FLUSH;
            cnt_n   = CNT_LOAD;
            redir_n = 1'b1;
          end
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state_n = IDLE;
          end else begin
            cnt_n = cnt_q - CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      rec_pc            <= '0;
      rec_fid           <= '0;
      rec_hist          <= '0;
      OUT_redirValid    <= 1'b0;
      OUT_redirPC       <= '0;
      OUT_redirFetchID  <= '0;
      OUT_redirHistory  <= '0;
      OUT_mispredFlush  <= 1'b0;
      OUT_flushSqN      <= '0;
      OUT_flushLoadSqN  <= '0;
      OUT_flushStoreSqN <= '0;
    end else begin
      state_q          <= state_n;
      cnt_q            <= cnt_n;
      OUT_redirValid   <= redir_n;
      OUT_mispredFlush <= (state_n != IDLE);
      if (accept) begin
        rec_pc            <= in_br.pc;
        rec_fid           <= in_br.fid;
        rec_hist          <= in_br.hist;
        OUT_flushSqN      <= in_br.sqn;
        OUT_flushLoadSqN  <= in_br.lsqn;
        OUT_flushStoreSqN <= in_br.ssqn;
      end
      if (redir_n) begin
        OUT_redirPC      <= src_pc;
        OUT_redirFetchID <= src_fid;
        OUT_redirHistory <= src_hist;
      end
    end
  end

  assign OUT_stallRename = OUT_mispredFlush;

endmodule
